// File: rtl/mtm_alu_ctrl_if.sv
`timescale 1ns/1ps
// mtm_alu_ctrl_if: byte input, ALU core launch/return and response handshake
// between the sequencing controller (master) and its surroundings (slave).
interface mtm_alu_ctrl_if;

  // Byte stream from the deserializer
  logic        in_valid;
  logic        in_cmd;
  logic [7:0]  in_byte;
  logic        in_ready;

  // ALU core launch and completion
  logic        core_start;
  logic [31:0] core_a;
  logic [31:0] core_b;
  logic [2:0]  core_op;
  logic        core_done;
  logic [31:0] core_c;
  logic [3:0]  core_flags;

  // Response towards the serializer
  logic        res_valid;
  logic        res_ready;
  logic        res_err;
  logic [2:0]  res_err_flags;
  logic [31:0] res_data;
  logic [3:0]  res_flags;

  // Controller side
  modport master (
    input  in_valid, in_cmd, in_byte,
    input  core_done, core_c, core_flags,
    input  res_ready,
    output in_ready,
    output core_start, core_a, core_b, core_op,
    output res_valid, res_err, res_err_flags, res_data, res_flags
  );

  // Deserializer / core / serializer side
  modport slave (
    output in_valid, in_cmd, in_byte,
    output core_done, core_c, core_flags,
    output res_ready,
    input  in_ready,
    input  core_start, core_a, core_b, core_op,
    input  res_valid, res_err, res_err_flags, res_data, res_flags
  );

endinterface

// File: rtl/mtm_alu_ctrl.sv
`timescale 1ns/1ps
// mtm_alu_ctrl: collects an 8-byte operand frame plus a command byte, checks
// framing, CRC-4 and opcode, launches one ALU core operation with a timeout,
// and returns the result or an error status over a valid/ready handshake.
module mtm_alu_ctrl #(
  parameter int CORE_TIMEOUT = 16,  // max cycles from core_start to core_done
  parameter int CNT_W        = 5    // timeout counter width, must hold CORE_TIMEOUT
) (
  input logic            clk,
  input logic            rst_n,
  mtm_alu_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,   // collecting data bytes (count 0..8)
    S_FLUSH = 3'd1,   // overlong frame: swallow bytes until the command byte
    S_EXEC  = 3'd2,   // one-cycle core launch
    S_WAIT  = 3'd3,   // waiting for core_done or timeout
    S_RESP  = 3'd4    // response presented until res_ready
  } state_t;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b100;
  localparam logic [2:0] OP_SUB = 3'b101;

  // Bit positions inside the {ERR_DATA, ERR_CRC, ERR_OP} error vector
  localparam int ERR_DATA = 2;
  localparam int ERR_CRC  = 1;
  localparam int ERR_OP   = 0;

  localparam logic [3:0]       FRAME_BYTES = 4'd8;
  localparam logic [CNT_W-1:0] TMO_LAST    = CNT_W'(CORE_TIMEOUT - 1);

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  state_t           state_q, state_d;
  logic [63:0]      opr_q;        // {B, A}; first received byte lands in [63:56]
  logic [3:0]       byte_cnt_q;   // accepted data bytes in this frame (0..8)
  logic [3:0]       crc_q;        // running CRC over the data bytes so far
  logic [2:0]       op_q;         // opcode of the last command byte
  logic [2:0]       err_q;        // {ERR_DATA, ERR_CRC, ERR_OP}
  logic             tmo_q;        // core did not answer in time
  logic [CNT_W-1:0] to_cnt_q;     // WAIT cycles elapsed since launch
  logic [31:0]      res_data_q;
  logic [3:0]       res_flags_q;

  // ---------------------------------------------------------------------------
  // CRC-4, polynomial x^4 + x + 1, MSB first, initial value 0
  // ---------------------------------------------------------------------------
  function automatic logic [3:0] crc4_bit(input logic [3:0] crc, input logic din);
    logic fb;
    fb = crc[3] ^ din;
    return {crc[2:0], 1'b0} ^ {2'b00, fb, fb};
  endfunction

  function automatic logic [3:0] crc4_byte(input logic [3:0] crc, input logic [7:0] data);
    logic [3:0] c;
    c = crc;
    for (int i = 7; i >= 0; i--) c = crc4_bit(c, data[i]);
    return c;
  endfunction

  function automatic logic [3:0] crc4_nibble(input logic [3:0] crc, input logic [3:0] data);
    logic [3:0] c;
    c = crc;
    for (int i = 3; i >= 0; i--) c = crc4_bit(c, data[i]);
    return c;
  endfunction

  // ---------------------------------------------------------------------------
  // Input decode
  // ---------------------------------------------------------------------------
  logic       accepting;
  logic       byte_hit;
  logic       data_hit;
  logic       cmd_hit;
  logic       frame_full;
  logic [2:0] cmd_op;
  logic [3:0] cmd_crc;
  logic [3:0] crc_byte_next;
  logic [3:0] crc_final;
  logic       crc_bad;
  logic       op_bad;
  logic       timeout_hit;
  logic       unused_cmd_msb;

  // Bytes are only taken while collecting or flushing; anything offered in
  // other states is dropped without raising an error.
  assign accepting  = (state_q == S_IDLE) || (state_q == S_FLUSH);
  assign byte_hit   = bus.in_valid && accepting;
  assign data_hit   = byte_hit && !bus.in_cmd;
  assign cmd_hit    = byte_hit && bus.in_cmd;
  assign frame_full = (byte_cnt_q == FRAME_BYTES);

  assign cmd_op         = bus.in_byte[6:4];
  assign cmd_crc        = bus.in_byte[3:0];
  assign unused_cmd_msb = bus.in_byte[7];

  // The command byte contributes {1'b1, OP} as the last four CRC bits, so the
  // full 68-bit check completes in the same cycle the command is accepted.
  assign crc_byte_next = crc4_byte(crc_q, bus.in_byte);
  assign crc_final     = crc4_nibble(crc_q, {1'b1, cmd_op});
  assign crc_bad       = (crc_final != cmd_crc);
  assign op_bad        = !(cmd_op inside {OP_AND, OP_OR, OP_ADD, OP_SUB});

  // A done pulse in the last allowed cycle still wins over the timeout.
  assign timeout_hit = (to_cnt_q == TMO_LAST) && !bus.core_done;

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  logic start;
  logic resp;

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: every clocked assignment is non-blocking so all registers update
    // from the same pre-edge values, whatever order the statements are in.
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state and state-decoded strobes.
  always_comb begin
    // NOTE: defaults first, so no path through the case leaves a variable
    // unassigned and a latch cannot be inferred.
    state_d = state_q;
    start   = 1'b0;
    resp    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (data_hit && frame_full) begin
          state_d = S_FLUSH;
        end else if (cmd_hit) begin
          if (frame_full && !crc_bad && !op_bad) state_d = S_EXEC;
          else                                   state_d = S_RESP;
        end
      end
      S_FLUSH: begin
        if (cmd_hit) state_d = S_RESP;
      end
      S_EXEC: begin
        start   = 1'b1;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (bus.core_done || timeout_hit) state_d = S_RESP;
      end
      S_RESP: begin
        resp = 1'b1;
        if (bus.res_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------

  // Frame assembly, error capture, timeout counting and result latching.
  always_ff @(posedge clk) begin
    // NOTE: the operand and result registers feed outputs directly, so they
    // are reset to give the all-zero output state after reset.
    if (!rst_n) begin
      opr_q       <= '0;
      byte_cnt_q  <= '0;
      crc_q       <= '0;
      op_q        <= '0;
      err_q       <= '0;
      tmo_q       <= 1'b0;
      to_cnt_q    <= '0;
      res_data_q  <= '0;
      res_flags_q <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (data_hit) begin
            if (frame_full) begin
              err_q[ERR_DATA] <= 1'b1;
            end else begin
              opr_q      <= {opr_q[55:0], bus.in_byte};
              byte_cnt_q <= byte_cnt_q + 4'd1;
              crc_q      <= crc_byte_next;
            end
          end else if (cmd_hit) begin
            op_q <= cmd_op;
            if (!frame_full) begin
              err_q <= 3'b100;
            end else begin
              err_q[ERR_CRC] <= crc_bad;
              err_q[ERR_OP]  <= op_bad;
            end
          end
        end
        S_FLUSH: begin
          // ERR_DATA is already recorded; bytes are simply discarded.
        end
        S_EXEC: begin
          to_cnt_q <= '0;
        end
        S_WAIT: begin
          to_cnt_q <= to_cnt_q + CNT_W'(1);
          if (bus.core_done) begin
            res_data_q  <= bus.core_c;
            res_flags_q <= bus.core_flags;
          end else if (timeout_hit) begin
            tmo_q <= 1'b1;
          end
        end
        S_RESP: begin
          if (bus.res_ready) begin
            byte_cnt_q  <= '0;
            crc_q       <= '0;
            err_q       <= '0;
            tmo_q       <= 1'b0;
            res_data_q  <= '0;
            res_flags_q <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // Operands and opcode come straight from the frame registers, which cannot
  // change while in_ready is low, so they stay stable from launch to done.
  assign bus.in_ready   = accepting;
  assign bus.core_start = start;
  assign bus.core_b     = opr_q[63:32];
  assign bus.core_a     = opr_q[31:0];
  assign bus.core_op    = op_q;

  // Response fields are only driven while the response is presented; a
  // timeout shows as res_err with an all-zero error vector.
  assign bus.res_valid     = resp;
  assign bus.res_err       = resp && ((|err_q) || tmo_q);
  assign bus.res_err_flags = resp ? err_q       : 3'b000;
  assign bus.res_data      = resp ? res_data_q  : 32'h0;
  assign bus.res_flags     = resp ? res_flags_q : 4'h0;

endmodule

// File: tb/tb_mtm_alu_ctrl.sv
`timescale 1ns/1ps
// tb_mtm_alu_ctrl: directed and randomized frames against a behavioural
// model of framing, CRC-4 (polynomial division), opcode legality, core
// latency/timeout and response handshake.
module tb_mtm_alu_ctrl;

  localparam int CORE_TIMEOUT = 16;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  mtm_alu_ctrl_if bus ();

  mtm_alu_ctrl #(.CORE_TIMEOUT(CORE_TIMEOUT), .CNT_W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int          n_data;   // data bytes sent before the command byte
    logic [31:0] b;
    logic [31:0] a;
    logic [2:0]  op;
    logic [3:0]  crc_xor;  // corruption applied to the correct CRC
    int          lat;      // core_done cycle after core_start (0 = never)
    int          hold;     // cycles res_ready is held low
  } frame_t;

  int checks = 0;
  int errors = 0;
  bit gaps   = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Remainder of {msg, 0000} divided by x^4 + x + 1.
  function automatic logic [3:0] crc_ref(input logic [67:0] msg);
    logic [71:0] r;
    r = {msg, 4'b0000};
    for (int i = 71; i >= 4; i--)
      if (r[i]) r[i -: 5] = r[i -: 5] ^ 5'b10011;
    return r[3:0];
  endfunction

  // Stand-in ALU core: returns {C, Carry, Overflow, Zero, Negative}.
  function automatic logic [35:0] core_model(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    logic [32:0] s;
    logic [31:0] c;
    logic        cy, ov;
    cy = 1'b0;
    ov = 1'b0;
    case (op)
      3'b000: c = a & b;
      3'b001: c = a | b;
      3'b100: begin
        s  = {1'b0, a} + {1'b0, b};
        c  = s[31:0];
        cy = s[32];
        ov = (a[31] == b[31]) && (c[31] != a[31]);
      end
      3'b101: begin
        s  = {1'b0, b} - {1'b0, a};
        c  = s[31:0];
        cy = s[32];
        ov = (a[31] != b[31]) && (c[31] != b[31]);
      end
      default: c = 32'h0;
    endcase
    return {c, cy, ov, (c == 32'h0), c[31]};
  endfunction

  function automatic logic [2:0] exp_err(input frame_t f);
    logic legal;
    legal = (f.op == 3'b000) || (f.op == 3'b001) || (f.op == 3'b100) || (f.op == 3'b101);
    if (f.n_data != 8) return 3'b100;
    return {1'b0, (f.crc_xor != 4'h0), !legal};
  endfunction

  function automatic frame_t mk_frame(input int n, input logic [31:0] b, input logic [31:0] a,
                                      input logic [2:0] op, input logic [3:0] cx,
                                      input int lat, input int hold);
    frame_t f;
    f.n_data = n; f.b = b; f.a = a; f.op = op;
    f.crc_xor = cx; f.lat = lat; f.hold = hold;
    return f;
  endfunction

  task automatic send_byte(input logic cmd, input logic [7:0] data);
    if (gaps) repeat ($urandom_range(0, 2)) tick();
    bus.in_valid = 1'b1;
    bus.in_cmd   = cmd;
    bus.in_byte  = data;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic send_frame(input frame_t f);
    logic [63:0] ops;
    logic [3:0]  crc;
    ops = {f.b, f.a};
    crc = crc_ref({f.b, f.a, 1'b1, f.op}) ^ f.crc_xor;
    for (int i = 0; i < f.n_data; i++) begin
      if (i < 8) send_byte(1'b0, ops[63 - 8*i -: 8]);
      else       send_byte(1'b0, 8'($urandom));
    end
    send_byte(1'b1, {1'b0, f.op, crc});
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, ":ctrl"},
          {bus.in_ready, bus.core_start, bus.res_valid, bus.res_err, bus.res_err_flags,
           bus.core_op, bus.res_flags}, {1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000, 4'h0});
    check({tag, ":operands"}, {bus.core_b, bus.core_a}, 64'h0);
    check({tag, ":data"}, bus.res_data, 32'h0);
  endtask

  // Expects the response to be presented now; holds it, then consumes it.
  task automatic take_resp(input int hold, input logic err, input logic [2:0] ef,
                           input logic [31:0] data, input logic [3:0] fl, input string tag);
    bit ok;
    check({tag, ":resp"},
          {bus.res_valid, bus.res_err, bus.res_err_flags, bus.res_data, bus.res_flags},
          {1'b1, err, ef, data, fl});
    ok = 1'b1;
    for (int i = 0; i < hold; i++) begin
      bus.res_ready = 1'b0;
      if ($urandom_range(1) == 1) begin   // stray core_done must be ignored
        bus.core_done  = 1'b1;
        bus.core_c     = $urandom;
        bus.core_flags = 4'($urandom);
      end
      tick();
      bus.core_done = 1'b0;
      if ({bus.res_valid, bus.res_err, bus.res_err_flags, bus.res_data, bus.res_flags,
           bus.in_ready, bus.core_start} !== {1'b1, err, ef, data, fl, 1'b0, 1'b0})
        ok = 1'b0;
    end
    if (hold > 0) check({tag, ":hold"}, ok, 1'b1);
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
    check({tag, ":release"}, {bus.res_valid, bus.in_ready}, 2'b01);
  endtask

  task automatic run_frame(input frame_t f, input string tag);
    logic [2:0]  ef;
    logic [35:0] cm;
    int          arrive;
    int          exp_arrive;
    bit          ok;
    ef = exp_err(f);
    send_frame(f);
    if (ef != 3'b000) begin
      check({tag, ":no_start"}, {bus.res_valid, bus.core_start}, 2'b10);
      take_resp(f.hold, 1'b1, ef, 32'h0, 4'h0, tag);
    end else begin
      check({tag, ":start"}, {bus.core_start, bus.res_valid, bus.in_ready}, 3'b100);
      check({tag, ":operands"}, {bus.core_b, bus.core_a}, {f.b, f.a});
      check({tag, ":op"}, bus.core_op, f.op);
      cm     = core_model(f.op, f.a, f.b);
      arrive = 0;
      ok     = 1'b1;
      for (int k = 1; k <= CORE_TIMEOUT + 4; k++) begin
        tick();
        bus.core_done = 1'b0;
        bus.in_valid  = 1'b0;
        if (bus.res_valid) begin
          arrive = k;
          break;
        end
        if (bus.core_start || bus.in_ready ||
            ({bus.core_b, bus.core_a, bus.core_op} !== {f.b, f.a, f.op}))
          ok = 1'b0;
        if (k == f.lat) begin
          bus.core_done  = 1'b1;
          bus.core_c     = cm[35:4];
          bus.core_flags = cm[3:0];
        end else begin
          bus.core_c     = $urandom;
          bus.core_flags = 4'($urandom);
        end
        if ($urandom_range(3) == 0) begin   // offered while not ready: dropped
          bus.in_valid = 1'b1;
          bus.in_cmd   = 1'($urandom);
          bus.in_byte  = 8'($urandom);
        end
      end
      check({tag, ":wait_hold"}, ok, 1'b1);
      exp_arrive = (f.lat >= 1 && f.lat <= CORE_TIMEOUT) ? f.lat + 1 : CORE_TIMEOUT + 1;
      check({tag, ":latency"}, arrive, exp_arrive);
      if (arrive == 0) return;
      if (exp_arrive == CORE_TIMEOUT + 1 && f.lat != CORE_TIMEOUT)
        take_resp(f.hold, 1'b1, 3'b000, 32'h0, 4'h0, tag);
      else
        take_resp(f.hold, 1'b0, 3'b000, cm[35:4], cm[3:0], tag);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed no end of test, expected $finish before time limit");
    $fatal(1);
  end

  initial begin
    frame_t f;
    rst_n          = 1'b0;
    bus.in_valid   = 1'b0;
    bus.in_cmd     = 1'b0;
    bus.in_byte    = 8'h0;
    bus.core_done  = 1'b0;
    bus.core_c     = 32'h0;
    bus.core_flags = 4'h0;
    bus.res_ready  = 1'b0;
    tick();
    tick();
    check_reset_outs("reset");
    rst_n = 1'b1;
    tick();

    // Clean ADD: 0xFFFFFFFF + 1 -> 0 with Carry and Zero
    run_frame(mk_frame(8, 32'h00000001, 32'hFFFFFFFF, 3'b100, 4'h0, 3, 0), "add");

    // Short and long frames
    run_frame(mk_frame(7, 32'h11223344, 32'h55667788, 3'b000, 4'h0, 1, 0), "short");
    run_frame(mk_frame(10, 32'hCAFEF00D, 32'h0BADBEEF, 3'b001, 4'h0, 1, 0), "long");
    run_frame(mk_frame(8, 32'h0000000F, 32'h000000F0, 3'b001, 4'h0, 2, 0), "after_long");

    // CRC and opcode errors
    run_frame(mk_frame(8, 32'h12345678, 32'h9ABCDEF0, 3'b000, 4'h1, 1, 0), "crc_err");
    run_frame(mk_frame(8, 32'h12345678, 32'h9ABCDEF0, 3'b011, 4'h0, 1, 0), "op_err");
    run_frame(mk_frame(8, 32'h12345678, 32'h9ABCDEF0, 3'b110, 4'h8, 1, 0), "both_err");

    // Backpressure, core_done on the last allowed cycle, and timeout
    run_frame(mk_frame(8, 32'h80000000, 32'h00000001, 3'b101, 4'h0, 4, 5), "backpressure");
    run_frame(mk_frame(8, 32'h7FFFFFFF, 32'h00000001, 3'b100, 4'h0, CORE_TIMEOUT, 0), "done_last");
    run_frame(mk_frame(8, 32'hA5A5A5A5, 32'h5A5A5A5A, 3'b001, 4'h0, 0, 4), "timeout");

    // Reset while waiting on the core, with a core_done in the reset cycle
    f = mk_frame(8, 32'hDEADBEEF, 32'h01234567, 3'b101, 4'h0, 0, 0);
    send_frame(f);
    check("rst_mid:start", bus.core_start, 1'b1);
    repeat (3) tick();
    rst_n          = 1'b0;
    bus.core_done  = 1'b1;
    bus.core_c     = 32'hFFFFFFFF;
    bus.core_flags = 4'hF;
    tick();
    bus.core_done = 1'b0;
    rst_n         = 1'b1;
    check_reset_outs("rst_mid");
    run_frame(mk_frame(8, 32'hFF00FF00, 32'hF0F0F0F0, 3'b000, 4'h0, 2, 1), "and_after_rst");

    // Randomized frames
    gaps = 1'b1;
    for (int n = 0; n < 40; n++) begin
      f.n_data  = ($urandom_range(9) < 8) ? 8 : int'($urandom_range(0, 11));
      f.b       = $urandom;
      f.a       = $urandom;
      f.op      = 3'($urandom);
      f.crc_xor = ($urandom_range(4) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
      f.lat     = ($urandom_range(9) == 0) ? 0 : int'($urandom_range(1, CORE_TIMEOUT + 3));
      f.hold    = int'($urandom_range(0, 4));
      run_frame(f, $sformatf("rand%0d", n));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
